// File: rtl/ticks_gen_pkg.sv
// Shared constants and the prescaler width helper for the ticks_gen timebase.
package ticks_pkg;

  localparam int unsigned TICKS_W       = 17;
  localparam int unsigned DIV_1MS_50MHZ = 50_000;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((33'd1 << w) < {1'b0, n}) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ticks_prescaler.sv
// Mod-DIV counter; wrap is high while the count sits on its terminal value.
module ticks_prescaler
  import ticks_pkg::*;
#(
  parameter int unsigned DIV = DIV_1MS_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap
);

  localparam int unsigned    PW   = clog2_min1(DIV);
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  logic [PW-1:0] r_pre;

  assign wrap = (r_pre == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (en) begin
      if (wrap) r_pre <= '0;
      else      r_pre <= r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/ticks_gen.sv
// Free-running timebase: clk / DIV prescaler drives a WIDTH-bit tick counter.
// Optional one-cycle `tick` pulse output when TICKS_GEN_PULSE_EN is defined.
module ticks_gen
  import ticks_pkg::*;
#(
  parameter int unsigned DIV   = DIV_1MS_50MHZ,
  parameter int unsigned WIDTH = TICKS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef TICKS_GEN_PULSE_EN
  output logic             tick,
`endif
  output logic [WIDTH-1:0] ticks
);

  logic             w_wrap;
  logic [WIDTH-1:0] r_ticks;

  ticks_prescaler #(
    .DIV (DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (start),
    .wrap (w_wrap)
  );

  // Rolls over silently at 2^WIDTH-1.
  always_ff @(posedge clk) begin
    if (rst)                 r_ticks <= '0;
    else if (start && w_wrap) r_ticks <= r_ticks + WIDTH'(1);
  end

  assign ticks = r_ticks;

`ifdef TICKS_GEN_PULSE_EN
  logic r_tick;

  always_ff @(posedge clk) begin
    if (rst) r_tick <= 1'b0;
    else     r_tick <= start && w_wrap;
  end

  assign tick = r_tick;
`endif

endmodule

// File: tb/tb_ticks_gen.sv
// Scoreboard bench for ticks_gen: three instances (DIV=4, DIV=1/WIDTH=3, DIV=5)
// exercised one at a time with directed vectors; a negedge monitor checks.
module tb_ticks_gen;

  typedef struct {
    int          sel;
    logic [16:0] ticks;
    logic        tick;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_a, start_a, rst_b, start_b, rst_c, start_c;
  logic [16:0] ticks_a;
  logic [2:0]  ticks_b;
  logic [7:0]  ticks_c;
`ifdef TICKS_GEN_PULSE_EN
  logic tick_a, tick_b, tick_c;
`endif

  exp_t        q[$];
  logic [16:0] prev_exp[3];
  int          n_checks;
  int          n_fail;

  ticks_gen #(.DIV(4), .WIDTH(17)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a),
`ifdef TICKS_GEN_PULSE_EN
    .tick(tick_a),
`endif
    .ticks(ticks_a));

  ticks_gen #(.DIV(1), .WIDTH(3)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b),
`ifdef TICKS_GEN_PULSE_EN
    .tick(tick_b),
`endif
    .ticks(ticks_b));

  ticks_gen #(.DIV(5), .WIDTH(8)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c),
`ifdef TICKS_GEN_PULSE_EN
    .tick(tick_c),
`endif
    .ticks(ticks_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs on the selected instance and queue the state
  // expected right after that edge; idle instances are held in reset.
  task automatic step(input int sel, input logic r, input logic s,
                      input logic [16:0] e, input string tag);
    exp_t x;
    rst_a = 1'b1; start_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0;
    rst_c = 1'b1; start_c = 1'b0;
    case (sel)
      0:       begin rst_a = r; start_a = s; end
      1:       begin rst_b = r; start_b = s; end
      default: begin rst_c = r; start_c = s; end
    endcase
    x.sel   = sel;
    x.ticks = e;
    x.tick  = !r && (e != prev_exp[sel]);
    x.tag   = tag;
    prev_exp[sel] = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      logic        act_tick;
      e = q.pop_front();
      case (e.sel)
        0:       act = ticks_a;
        1:       act = {14'd0, ticks_b};
        default: act = {9'd0, ticks_c};
      endcase
      n_checks++;
      if (act !== e.ticks) begin
        n_fail++;
        $display("FAIL %s inst%0d ticks: got %0d expected %0d @%0t",
                 e.tag, e.sel, act, e.ticks, $time);
      end
      act_tick = 1'b0;
`ifdef TICKS_GEN_PULSE_EN
      case (e.sel)
        0:       act_tick = tick_a;
        1:       act_tick = tick_b;
        default: act_tick = tick_c;
      endcase
      n_checks++;
      if (act_tick !== e.tick) begin
        n_fail++;
        $display("FAIL %s inst%0d tick: got %b expected %b @%0t",
                 e.tag, e.sel, act_tick, e.tick, $time);
      end
`endif
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) prev_exp[i] = '0;

    // DIV=4: reset with start high, then first ticks at 4 and 8 edges.
    repeat (3) step(0, 1, 1, 0, "t1_rst");
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 17'(i / 4), "t1_run");

    // Pause mid-period, then resume the partial period.
    step(0, 1, 0, 0, "t2_rst");
    repeat (2)  step(0, 0, 1, 0, "t2_pre");
    repeat (10) step(0, 0, 0, 0, "t2_pause");
    step(0, 0, 1, 0, "t2_resume");
    step(0, 0, 1, 1, "t2_resume");
    repeat (3)  step(0, 0, 1, 1, "t2_run");
    step(0, 0, 1, 2, "t2_run");

    // Reset at pre=3 together with start: reset wins, then a full period.
    repeat (3) step(0, 0, 1, 2, "t4_pre");
    step(0, 1, 1, 0, "t6_rst_start");
    repeat (3) step(0, 0, 1, 0, "t4_full");
    step(0, 0, 1, 1, "t4_full");

    // DIV=1, WIDTH=3: increments every edge and wraps 7 -> 0.
    step(1, 1, 1, 0, "t3_rst");
    for (int i = 1; i <= 9; i++) step(1, 0, 1, 17'(i % 8), "t3_wrap");
    step(1, 0, 0, 1, "t3_pause");

    // DIV=5: tick coincides with ticks change and stays low while paused.
    step(2, 1, 1, 0, "t5_rst");
    for (int i = 1; i <= 9; i++) step(2, 0, 1, 17'(i / 5), "t5_run");
    repeat (3) step(2, 0, 0, 1, "t5_pause");
    step(2, 0, 1, 2, "t5_resume");
    for (int i = 1; i <= 10; i++) step(2, 0, 1, 17'(2 + i / 5), "t5_run2");

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
